// File: rtl/graphic_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | graphic_pkg                                                          |
// | Shared definitions for the box sequencer: sequencer states, default  |
// | coordinate width and command-record field widths.                    |
// | Optional feature macro: BOX_OUTLINE_EN (adds the outline flag bit).  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package graphic_pkg;

  localparam int COORD_W_DEF = 12;
  localparam int FG_W        = 4;

`ifdef BOX_OUTLINE_EN
  localparam int OUTLINE_W = 1;
`else
  localparam int OUTLINE_W = 0;
`endif

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_START  = 3'd2,
    ST_WAIT   = 3'd3,
    ST_NEXT   = 3'd4,
    ST_RETIRE = 3'd5
  } seq_state_t;

  // Queued command record: {outline?, fg, h, w, y, x}, x in the low bits.
  function automatic int cmd_rec_w(input int coord_w);
    return 4 * coord_w + FG_W + OUTLINE_W;
  endfunction

endpackage
`default_nettype wire

// File: rtl/box_sequencer_cmd_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | cmd_fifo                                                             |
// | Synchronous first-word-fall-through command queue with flush.        |
// | DEPTH must be a power of two (>= 2). A push while full is dropped.   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module cmd_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr[AW-1:0]];

  // Pointer update; flush discards every queued entry in one cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  // Entry storage needs no reset: only slots between the pointers are read.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule
`default_nettype wire

// File: rtl/box_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | box_sequencer                                                        |
// | Queues box-fill commands and walks each box row by row, handing one  |
// | span at a time to the box unit (bu_start / bu_done handshake).       |
// | Optional feature macro: BOX_OUTLINE_EN (outline-only boxes).         |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module box_sequencer
  import graphic_pkg::*;
#(
  parameter int COORD_W    = COORD_W_DEF,
  parameter int FIFO_DEPTH = 4
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [COORD_W-1:0] cmd_x,
  input  logic [COORD_W-1:0] cmd_y,
  input  logic [COORD_W-1:0] cmd_w,
  input  logic [COORD_W-1:0] cmd_h,
  input  logic [3:0]         cmd_fg,
  input  logic               cmd_outline,
  output logic               bu_start,
  output logic [COORD_W-1:0] bu_width,
  output logic [3:0]         bu_fg,
  input  logic               bu_done,
  output logic [COORD_W-1:0] row_x,
  output logic [COORD_W-1:0] row_y,
  input  logic               abort,
  output logic               busy,
  output logic               cmd_done
);

  localparam int REC_W = cmd_rec_w(COORD_W);
  localparam logic [COORD_W-1:0] ONE = COORD_W'(1);
  localparam logic [COORD_W-1:0] TWO = COORD_W'(2);

  seq_state_t         state;
  logic [COORD_W-1:0] rows_left;
  logic [REC_W-1:0]   rec_in;
  logic [REC_W-1:0]   rec_out;
  logic               fifo_full;
  logic               fifo_empty;
  logic [COORD_W-1:0] head_x;
  logic [COORD_W-1:0] head_y;
  logic [COORD_W-1:0] head_w;
  logic [COORD_W-1:0] head_h;
  logic [3:0]         head_fg;

`ifdef BOX_OUTLINE_EN
  logic               head_outline;
  logic               outline_r;
  logic               mid_row;
  logic               right_side;
  logic               next_mid;
  logic [COORD_W-1:0] org_x;
  logic [COORD_W-1:0] box_w;

  assign rec_in       = {cmd_outline, cmd_fg, cmd_h, cmd_w, cmd_y, cmd_x};
  assign head_outline = rec_out[4*COORD_W+4];
  // Row about to be started is a middle row when it is not the last one.
  assign next_mid     = outline_r && (rows_left != TWO);
`else
  logic unused_outline;

  assign rec_in         = {cmd_fg, cmd_h, cmd_w, cmd_y, cmd_x};
  assign unused_outline = cmd_outline;
`endif

  assign head_x  = rec_out[0 +: COORD_W];
  assign head_y  = rec_out[COORD_W +: COORD_W];
  assign head_w  = rec_out[2*COORD_W +: COORD_W];
  assign head_h  = rec_out[3*COORD_W +: COORD_W];
  assign head_fg = rec_out[4*COORD_W +: 4];

  assign cmd_ready = !fifo_full;
  assign busy      = (state != ST_IDLE);

  cmd_fifo #(
    .WIDTH (REC_W),
    .DEPTH (FIFO_DEPTH)
  ) u_cmd_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .flush   (abort),
    .push    (cmd_valid),
    .din     (rec_in),
    .full    (fifo_full),
    .pop     (state == ST_LOAD),
    .dout    (rec_out),
    .empty   (fifo_empty)
  );

  // Sequencer FSM with registered span outputs; abort overrides every state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      rows_left  <= '0;
      row_x      <= '0;
      row_y      <= '0;
      bu_width   <= '0;
      bu_fg      <= '0;
      bu_start   <= 1'b0;
      cmd_done   <= 1'b0;
`ifdef BOX_OUTLINE_EN
      outline_r  <= 1'b0;
      mid_row    <= 1'b0;
      right_side <= 1'b0;
      org_x      <= '0;
      box_w      <= '0;
`endif
    end else begin
      bu_start <= 1'b0;
      cmd_done <= 1'b0;
      if (abort) begin
        state <= ST_IDLE;
      end else begin
        case (state)
          ST_IDLE: begin
            if (!fifo_empty) state <= ST_LOAD;
          end
          ST_LOAD: begin
            row_x     <= head_x;
            row_y     <= head_y;
            rows_left <= head_h;
            bu_width  <= head_w - ONE;
            bu_fg     <= head_fg;
`ifdef BOX_OUTLINE_EN
            outline_r  <= head_outline;
            mid_row    <= 1'b0;
            right_side <= 1'b0;
            org_x      <= head_x;
            box_w      <= head_w;
`endif
            if ((head_w == '0) || (head_h == '0)) begin
              state    <= ST_RETIRE;
              cmd_done <= 1'b1;
            end else begin
              state    <= ST_START;
              bu_start <= 1'b1;
            end
          end
          ST_START: begin
            state <= ST_WAIT;
          end
          ST_WAIT: begin
            if (bu_done) begin
`ifdef BOX_OUTLINE_EN
              // Left edge pixel of a middle row done: go straight to the right edge.
              if (mid_row && !right_side) begin
                state      <= ST_START;
                bu_start   <= 1'b1;
                right_side <= 1'b1;
                row_x      <= org_x + box_w - ONE;
              end else begin
                state <= ST_NEXT;
              end
`else
              state <= ST_NEXT;
`endif
            end
          end
          ST_NEXT: begin
            rows_left <= rows_left - ONE;
            row_y     <= row_y + ONE;
            if (rows_left != ONE) begin
              state    <= ST_START;
              bu_start <= 1'b1;
`ifdef BOX_OUTLINE_EN
              mid_row    <= next_mid;
              right_side <= 1'b0;
              row_x      <= org_x;
              bu_width   <= next_mid ? '0 : (box_w - ONE);
`endif
            end else begin
              state    <= ST_RETIRE;
              cmd_done <= 1'b1;
            end
          end
          ST_RETIRE: begin
            state <= fifo_empty ? ST_IDLE : ST_LOAD;
          end
          default: begin
            state <= ST_IDLE;
          end
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_box_sequencer.sv
`timescale 1ns/1ps
// Testbench for box_sequencer: randomized commands checked against a
// row-list reference model; a behavioural box unit answers each bu_start.
// Build with BOX_OUTLINE_EN defined to exercise outline boxes.
module tb_box_sequencer;

  localparam int CW    = 12;
  localparam int DEPTH = 4;
  localparam logic [CW-1:0] C1 = CW'(1);

  typedef struct packed {
    logic [CW-1:0] w;
    logic [CW-1:0] x;
    logic [CW-1:0] y;
    logic [3:0]    fg;
  } span_t;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_outline = 1'b0;
  logic          bu_done = 1'b0;
  logic          abort = 1'b0;
  logic [CW-1:0] cmd_x = '0, cmd_y = '0, cmd_w = '0, cmd_h = '0;
  logic [3:0]    cmd_fg = '0;
  logic          cmd_ready, bu_start, busy, cmd_done;
  logic [CW-1:0] bu_width, row_x, row_y;
  logic [3:0]    bu_fg;

  int checks = 0;
  int passes = 0;
  int cyc = 0;
  int stab_err = 0;
  int push_cyc = 0;
  span_t span_q[$];
  span_t exp_q[$];
  int    st_q[$];
  int    done_q[$];

  box_sequencer #(.COORD_W(CW), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset_n(reset_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_x(cmd_x), .cmd_y(cmd_y), .cmd_w(cmd_w), .cmd_h(cmd_h),
    .cmd_fg(cmd_fg), .cmd_outline(cmd_outline),
    .bu_start(bu_start), .bu_width(bu_width), .bu_fg(bu_fg), .bu_done(bu_done),
    .row_x(row_x), .row_y(row_y), .abort(abort), .busy(busy), .cmd_done(cmd_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural box unit: span of N pixels answers bu_done N+2 cycles after bu_start.
  initial begin
    span_t snap;
    int    n;
    bit    dropped;
    forever begin
      @(negedge clk);
      while (bu_start && reset_n) begin
        snap = {bu_width, row_x, row_y, bu_fg};
        n = int'(bu_width) + 1;
        dropped = 1'b0;
        for (int i = 0; i < n + 2; i++) begin
          @(negedge clk);
          if (abort || !reset_n || !busy) begin dropped = 1'b1; break; end
          if ({bu_width, row_x, row_y, bu_fg} !== snap) stab_err++;
        end
        if (!dropped) begin
          bu_done = 1'b1;
          @(negedge clk);
          bu_done = 1'b0;
        end
      end
    end
  end

  // Span and retire logger.
  initial begin
    span_t s;
    forever begin
      @(negedge clk);
      if (bu_start) begin
        s = {bu_width, row_x, row_y, bu_fg};
        span_q.push_back(s);
        st_q.push_back(cyc);
      end
      if (cmd_done) done_q.push_back(cyc);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time exhausted");
    $fatal(1);
  end

  // Reference model: a box is h rows of (w-1, x, y+r) spans; outline middle rows are two pixels.
  task automatic model_cmd(input logic [CW-1:0] x, input logic [CW-1:0] y, input logic [CW-1:0] w,
                           input logic [CW-1:0] h, input logic [3:0] fg, input logic ol);
    span_t s;
    bit use_ol;
`ifdef BOX_OUTLINE_EN
    use_ol = ol;
`else
    use_ol = 1'b0;
`endif
    if (w == '0 || h == '0) return;
    for (int r = 0; r < int'(h); r++) begin
      s.y  = CW'(int'(y) + r);
      s.fg = fg;
      if (use_ol && r != 0 && r != int'(h) - 1) begin
        s.w = '0; s.x = x; exp_q.push_back(s);
        s.x = CW'(int'(x) + int'(w) - 1); exp_q.push_back(s);
      end else begin
        s.w = w - C1; s.x = x; exp_q.push_back(s);
      end
    end
  endtask

  task automatic push(input logic [CW-1:0] x, input logic [CW-1:0] y, input logic [CW-1:0] w,
                      input logic [CW-1:0] h, input logic [3:0] fg, input logic ol);
    int waitc = 0;
    cmd_x = x; cmd_y = y; cmd_w = w; cmd_h = h; cmd_fg = fg; cmd_outline = ol;
    cmd_valid = 1'b1;
    while (!cmd_ready && waitc < 3000) begin @(negedge clk); waitc++; end
    if (waitc >= 3000) begin
      checks++;
      $display("FAIL push_timeout: cmd_ready=%0b after %0d cycles, required 1", cmd_ready, waitc);
    end
    push_cyc = cyc;
    model_cmd(x, y, w, h, fg, ol);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input int n, input int budget);
    int k = 0;
    while ((done_q.size() < n || busy) && k < budget) begin @(negedge clk); k++; end
    if (k >= budget) begin
      checks++;
      $display("FAIL wait_done_timeout: retired %0d, required %0d", done_q.size(), n);
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic clear_logs();
    span_q.delete(); exp_q.delete(); st_q.delete(); done_q.delete();
    stab_err = 0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (busy !== 1'b0) $display("FAIL rst_busy: got %0b want 0", busy); else passes++;
    checks++; if (bu_start !== 1'b0) $display("FAIL rst_bu_start: got %0b want 0", bu_start); else passes++;
    checks++; if (cmd_done !== 1'b0) $display("FAIL rst_cmd_done: got %0b want 0", cmd_done); else passes++;
    checks++; if (row_x !== '0) $display("FAIL rst_row_x: got %0h want 0", row_x); else passes++;
    checks++; if (row_y !== '0) $display("FAIL rst_row_y: got %0h want 0", row_y); else passes++;
    checks++; if (bu_width !== '0) $display("FAIL rst_bu_width: got %0h want 0", bu_width); else passes++;
    checks++; if (bu_fg !== 4'h0) $display("FAIL rst_bu_fg: got %0h want 0", bu_fg); else passes++;
    reset_n = 1'b1;
    @(negedge clk);
    checks++; if (cmd_ready !== 1'b1) $display("FAIL rst_cmd_ready: got %0b want 1", cmd_ready); else passes++;
    checks++; if (busy !== 1'b0) $display("FAIL rst_idle_busy: got %0b want 0", busy); else passes++;
  endtask

  task automatic test_single_box();
    clear_logs();
    push(12'd10, 12'd20, 12'd5, 12'd3, 4'hA, 1'b0);
    wait_done(1, 500);
    checks++; if (span_q.size() != 3) $display("FAIL box_span_count: got %0d want 3", span_q.size()); else passes++;
    for (int i = 0; i < exp_q.size() && i < span_q.size(); i++) begin
      checks++; if (span_q[i] !== exp_q[i]) $display("FAIL box_span%0d: got %h want %h", i, span_q[i], exp_q[i]); else passes++;
    end
    if (span_q.size() == 3) begin
      checks++; if (span_q[2].y !== 12'd22) $display("FAIL box_last_row_y: got %0d want 22", span_q[2].y); else passes++;
    end
    checks++; if (done_q.size() != 1) $display("FAIL box_done_count: got %0d want 1", done_q.size()); else passes++;
    if (st_q.size() == 3) begin
      checks++; if (st_q[1] - st_q[0] != 9) $display("FAIL box_latency01: got %0d want 9", st_q[1] - st_q[0]); else passes++;
      checks++; if (st_q[2] - st_q[1] != 9) $display("FAIL box_latency12: got %0d want 9", st_q[2] - st_q[1]); else passes++;
      if (done_q.size() == 1) begin
        checks++; if (done_q[0] <= st_q[2] + 7) $display("FAIL box_done_after_last: done at %0d, last bu_done at %0d", done_q[0], st_q[2] + 7); else passes++;
      end
    end
    checks++; if (stab_err != 0) $display("FAIL box_wait_stable: got %0d changes want 0", stab_err); else passes++;
  endtask

  task automatic test_degenerate();
    for (int k = 0; k < 2; k++) begin
      clear_logs();
      if (k == 0) push(12'd3, 12'd4, 12'd0, 12'd3, 4'h1, 1'b0);
      else        push(12'd3, 12'd4, 12'd7, 12'd0, 4'h2, 1'b0);
      wait_done(1, 100);
      checks++; if (span_q.size() != 0) $display("FAIL zero%0d_no_start: got %0d starts want 0", k, span_q.size()); else passes++;
      checks++; if (done_q.size() != 1) $display("FAIL zero%0d_done_count: got %0d want 1", k, done_q.size()); else passes++;
      if (done_q.size() == 1) begin
        checks++;
        if (done_q[0] - push_cyc > 5 || done_q[0] <= push_cyc)
          $display("FAIL zero%0d_done_latency: got %0d cycles after push want 1..5", k, done_q[0] - push_cyc);
        else passes++;
      end
    end
  endtask

  task automatic test_wrap();
    clear_logs();
    push(12'd7, 12'hFFF, 12'd3, 12'd2, 4'h5, 1'b0);
    wait_done(1, 200);
    checks++; if (span_q.size() != 2) $display("FAIL wrap_count: got %0d want 2", span_q.size()); else passes++;
    if (span_q.size() == 2) begin
      checks++; if (span_q[0].y !== 12'hFFF) $display("FAIL wrap_y0: got %h want fff", span_q[0].y); else passes++;
      checks++; if (span_q[1].y !== 12'h000) $display("FAIL wrap_y1: got %h want 000", span_q[1].y); else passes++;
    end
  endtask

  task automatic test_back_to_back();
    clear_logs();
    push(12'd50, 12'd60, 12'd6, 12'd3, 4'h3, 1'b0);
    for (int i = 0; i < 4; i++)
      push(CW'($urandom), CW'($urandom), CW'($urandom_range(1, 8)), CW'($urandom_range(1, 3)), 4'($urandom), 1'b0);
    checks++; if (cmd_ready !== 1'b0) $display("FAIL b2b_full_ready: got %0b want 0", cmd_ready); else passes++;
    wait_done(5, 3000);
    checks++; if (done_q.size() != 5) $display("FAIL b2b_done_count: got %0d want 5", done_q.size()); else passes++;
    checks++; if (span_q.size() != exp_q.size()) $display("FAIL b2b_span_count: got %0d want %0d", span_q.size(), exp_q.size()); else passes++;
    for (int i = 0; i < exp_q.size() && i < span_q.size(); i++) begin
      checks++; if (span_q[i] !== exp_q[i]) $display("FAIL b2b_span%0d: got %h want %h", i, span_q[i], exp_q[i]); else passes++;
    end
    checks++; if (cmd_ready !== 1'b1) $display("FAIL b2b_ready_after: got %0b want 1", cmd_ready); else passes++;
  endtask

  task automatic test_random();
    clear_logs();
    for (int i = 0; i < 16; i++) begin
      push(CW'($urandom), CW'($urandom), CW'($urandom_range(0, 10)), CW'($urandom_range(0, 4)),
           4'($urandom), 1'($urandom));
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    wait_done(16, 20000);
    checks++; if (done_q.size() != 16) $display("FAIL rnd_done_count: got %0d want 16", done_q.size()); else passes++;
    checks++; if (span_q.size() != exp_q.size()) $display("FAIL rnd_span_count: got %0d want %0d", span_q.size(), exp_q.size()); else passes++;
    for (int i = 0; i < exp_q.size() && i < span_q.size(); i++) begin
      checks++; if (span_q[i] !== exp_q[i]) $display("FAIL rnd_span%0d: got %h want %h", i, span_q[i], exp_q[i]); else passes++;
    end
    checks++; if (stab_err != 0) $display("FAIL rnd_wait_stable: got %0d changes want 0", stab_err); else passes++;
  endtask

  task automatic test_abort();
    int k = 0;
    clear_logs();
    push(12'd1, 12'd1, 12'd3, 12'd3, 4'h6, 1'b0);
    push(12'd2, 12'd2, 12'd2, 12'd2, 4'h7, 1'b0);
    push(12'd3, 12'd3, 12'd2, 12'd2, 4'h8, 1'b0);
    while (st_q.size() < 2 && k < 200) begin @(negedge clk); k++; end
    if (k >= 200) begin checks++; $display("FAIL abort_row2_timeout: starts %0d want 2", st_q.size()); end
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    checks++; if (busy !== 1'b0) $display("FAIL abort_busy: got %0b want 0", busy); else passes++;
    checks++; if (cmd_ready !== 1'b1) $display("FAIL abort_ready: got %0b want 1", cmd_ready); else passes++;
    repeat (30) @(negedge clk);
    checks++; if (st_q.size() != 2) $display("FAIL abort_no_more_starts: got %0d want 2", st_q.size()); else passes++;
    checks++; if (done_q.size() != 0) $display("FAIL abort_no_done: got %0d want 0", done_q.size()); else passes++;
    checks++; if (busy !== 1'b0) $display("FAIL abort_stays_idle: got %0b want 0", busy); else passes++;
  endtask

  task automatic test_reset_mid();
    int k = 0;
    clear_logs();
    push(12'd9, 12'd9, 12'd4, 12'd3, 4'h4, 1'b0);
    push(12'd8, 12'd8, 12'd4, 12'd3, 4'h4, 1'b0);
    while (st_q.size() < 1 && k < 200) begin @(negedge clk); k++; end
    if (k >= 200) begin checks++; $display("FAIL rmid_start_timeout: starts %0d want 1", st_q.size()); end
    @(negedge clk);
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    checks++; if (busy !== 1'b0) $display("FAIL rmid_busy: got %0b want 0", busy); else passes++;
    checks++; if (row_x !== '0) $display("FAIL rmid_row_x: got %0h want 0", row_x); else passes++;
    repeat (30) @(negedge clk);
    checks++; if (st_q.size() != 1) $display("FAIL rmid_no_more_starts: got %0d want 1", st_q.size()); else passes++;
    checks++; if (done_q.size() != 0) $display("FAIL rmid_no_done: got %0d want 0", done_q.size()); else passes++;
  endtask

  task automatic test_outline();
    int want;
`ifdef BOX_OUTLINE_EN
    want = 6;
`else
    want = 4;
`endif
    clear_logs();
    push(12'd100, 12'd50, 12'd4, 12'd4, 4'h9, 1'b1);
    wait_done(1, 300);
    checks++; if (span_q.size() != want) $display("FAIL outline_count: got %0d want %0d", span_q.size(), want); else passes++;
    for (int i = 0; i < exp_q.size() && i < span_q.size(); i++) begin
      checks++; if (span_q[i] !== exp_q[i]) $display("FAIL outline_span%0d: got %h want %h", i, span_q[i], exp_q[i]); else passes++;
    end
  endtask

  initial begin
    test_reset();
    test_single_box();
    test_degenerate();
    test_wrap();
    test_back_to_back();
    test_outline();
    test_random();
    test_abort();
    test_reset_mid();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
